// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one byte-wide RAM port between instruction fetch (IF, word reads)
// and the MEM stage (byte/half/word loads and stores). A granted access is
// split into 1, 2 or 4 single-byte RAM cycles. Bytes are ordered
// little-endian: byte k sits at addr+k and maps to data bits [8k+7:8k].
//
// Ports
//   clk_in, rst_in      clock (rising edge), asynchronous active-low reset
//   rdy_in              chip enable; low pauses sequencing
//   if_req/if_addr      fetch request (held until if_done), word address
//   if_flush            abort a pending or in-flight fetch
//   if_done/if_data     one-cycle completion pulse with the fetched word
//   mem_req/mem_we      MEM request (held until mem_done), 1 = store
//   mem_addr/mem_size   byte address, size 0=byte 1=half 2/3=word
//   mem_wdata           store data, low bytes used
//   mem_done/mem_rdata  one-cycle completion pulse, zero-extended load data
//   ram_addr/ram_wr     RAM byte address and write strobe
//   ram_dout/ram_din    RAM write byte, RAM read byte
//
// RAM read timing: an address driven during cycle c returns its byte on
// ram_din during cycle c+1, which is captured at the edge ending that cycle.
// Address issue and read capture are tracked by separate counters so that a
// pause (rdy_in low) stops new addresses while in-flight bytes still land.

module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter bit          MEM_PRIORITY = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_size,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_mem_q, owner_mem_d;  // 1 = MEM owns the port
    logic                  rr_mem_q, rr_mem_d;        // 1 = MEM wins next conflict
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            len_q, len_d;              // bytes in this access
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            iss_q, iss_d;              // bytes whose address went out
    logic [2:0]            cap_q, cap_d;              // read bytes captured
    logic                  issue_v_q, issue_v_d;      // ram_addr carries a new read
    logic                  data_v_q, data_v_d;        // ram_din carries a wanted byte
    logic [31:0]           result_q, result_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_dout_q, ram_dout_d;

    logic                  if_ok;
    logic                  pick_mem;
    logic                  issue_more;
    logic [ADDR_WIDTH-1:0] next_addr;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'd0:    size_len = 3'd1;
            2'd1:    size_len = 3'd2;
            default: size_len = 3'd4;
        endcase
    endfunction

    // A fetch raised together with a flush is already stale.
    assign if_ok      = if_req && !if_flush;
    assign pick_mem   = mem_req && (!if_ok || MEM_PRIORITY || rr_mem_q);
    assign issue_more = rdy_in && (iss_q < len_q);
    // Wraps modulo 2^ADDR_WIDTH.
    assign next_addr  = base_q + ADDR_WIDTH'(iss_q);

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        rr_mem_d    = rr_mem_q;
        base_d      = base_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        iss_d       = iss_q;
        cap_d       = cap_q;
        issue_v_d   = 1'b0;
        data_v_d    = issue_v_q;
        result_d    = result_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;

        unique case (state_q)
            StIdle: begin
                if (rdy_in && (if_ok || mem_req)) begin
                    owner_mem_d = pick_mem;
                    if (if_ok && mem_req) begin
                        rr_mem_d = !pick_mem;
                    end
                    base_d     = pick_mem ? mem_addr : if_addr;
                    len_d      = pick_mem ? size_len(mem_size) : 3'd4;
                    wdata_d    = mem_wdata;
                    iss_d      = 3'd1;
                    cap_d      = 3'd0;
                    result_d   = 32'd0;
                    ram_addr_d = pick_mem ? mem_addr : if_addr;
                    if (pick_mem && mem_we) begin
                        ram_dout_d = mem_wdata[7:0];
                        state_d    = StWrite;
                    end else begin
                        issue_v_d  = 1'b1;
                        state_d    = StRead;
                    end
                end
            end

            StRead: begin
                // Captures ignore rdy_in: the RAM already answered.
                if (data_v_q) begin
                    result_d[{cap_q[1:0], 3'b000} +: 8] = ram_din;
                    cap_d = cap_q + 3'd1;
                end
                if (issue_more) begin
                    ram_addr_d = next_addr;
                    iss_d      = iss_q + 3'd1;
                    issue_v_d  = 1'b1;
                end
                if (rdy_in && (cap_d == len_q)) begin
                    state_d = StDone;
                end
                // Fetch abort: drop the in-flight byte and issue nothing more.
                if (if_flush && !owner_mem_q) begin
                    state_d    = StIdle;
                    issue_v_d  = 1'b0;
                    data_v_d   = 1'b0;
                    iss_d      = iss_q;
                    ram_addr_d = ram_addr_q;
                end
            end

            StWrite: begin
                if (rdy_in) begin
                    if (iss_q == len_q) begin
                        state_d = StDone;
                    end else begin
                        ram_addr_d = next_addr;
                        ram_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
                        iss_d      = iss_q + 3'd1;
                    end
                end
            end

            StDone: begin
                if (rdy_in) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            rr_mem_q    <= 1'b0;
            base_q      <= '0;
            len_q       <= 3'd0;
            wdata_q     <= 32'd0;
            iss_q       <= 3'd0;
            cap_q       <= 3'd0;
            issue_v_q   <= 1'b0;
            data_v_q    <= 1'b0;
            result_q    <= 32'd0;
            ram_addr_q  <= '0;
            ram_dout_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            rr_mem_q    <= rr_mem_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            iss_q       <= iss_d;
            cap_q       <= cap_d;
            issue_v_q   <= issue_v_d;
            data_v_q    <= data_v_d;
            result_q    <= result_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    // Strobes are gated by rdy_in so a pause suppresses writes and defers done.
    assign ram_wr    = (state_q == StWrite) && rdy_in;
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign if_done   = (state_q == StDone) && !owner_mem_q && rdy_in;
    assign mem_done  = (state_q == StDone) && owner_mem_q && rdy_in;
    assign if_data   = ((state_q == StDone) && !owner_mem_q) ? result_q : 32'd0;
    assign mem_rdata = ((state_q == StDone) && owner_mem_q) ? result_q : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority instance (u_dut) carries most
// sequences, a round-robin instance (u_rr) covers alternating conflicts.
// Stimulus pushes the expected completion (owner, data, cycle) into a queue;
// a monitor pops and compares whenever a done pulse appears.

module tb_mem_arbiter;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;

    logic        if_req, if_flush, if_done, mem_req, mem_we, mem_done, ram_wr;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr;
    logic [1:0]  mem_size;
    logic [7:0]  ram_dout, ram_din;

    logic        r_if_req, r_if_flush, r_if_done, r_mem_req, r_mem_we, r_mem_done, r_ram_wr;
    logic [31:0] r_if_addr, r_if_data, r_mem_addr, r_mem_wdata, r_mem_rdata, r_ram_addr;
    logic [1:0]  r_mem_size;
    logic [7:0]  r_ram_dout, r_ram_din;

    int   cyc = 0;
    int   n_writes = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t rr_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_PRIORITY(1'b1)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_PRIORITY(1'b0)) u_rr (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(1'b1),
        .if_req(r_if_req), .if_addr(r_if_addr), .if_flush(r_if_flush),
        .if_done(r_if_done), .if_data(r_if_data),
        .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_size(r_mem_size),
        .mem_wdata(r_mem_wdata), .mem_done(r_mem_done), .mem_rdata(r_mem_rdata),
        .ram_addr(r_ram_addr), .ram_wr(r_ram_wr), .ram_dout(r_ram_dout), .ram_din(r_ram_din)
    );

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h13;
            32'h101: rom = 8'h00;
            32'h102: rom = 8'h05;
            32'h103: rom = 8'h93;
            32'h200: rom = 8'hB7;
            32'h201: rom = 8'h02;
            32'h202: rom = 8'h00;
            32'h203: rom = 8'h10;
            32'h400: rom = 8'h78;
            32'h401: rom = 8'h56;
            32'h402: rom = 8'h34;
            32'h403: rom = 8'h12;
            default: rom = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Synchronous RAM: byte for the address seen at an edge appears after it.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ram_din   <= rom(ram_addr);
        r_ram_din <= rom(r_ram_addr);
        if (ram_wr) n_writes <= n_writes + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done || mem_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_owner", {31'd0, mem_done}, {31'd0, e.is_mem});
                    check("done_cycle", cyc, e.cyc);
                    if (e.chk_data) check("done_data", e.is_mem ? mem_rdata : if_data, e.data);
                end
            end
            if (r_if_done || r_mem_done) begin
                if (rr_q.size() == 0) begin
                    check("rr_unexpected_done", {30'd0, r_if_done, r_mem_done}, 32'd0);
                end else begin
                    e = rr_q.pop_front();
                    check("rr_done_owner", {31'd0, r_mem_done}, {31'd0, e.is_mem});
                    check("rr_done_cycle", cyc, e.cyc);
                    check("rr_done_data", e.is_mem ? r_mem_rdata : r_if_data, e.data);
                end
            end
        end
    endtask

    // Requesters drop req in their done cycle; bounded by a cycle budget.
    task automatic drain(input int budget);
        int n = 0;
        while ((if_req || mem_req || r_if_req || r_mem_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (if_done) if_req = 1'b0;
            if (mem_done) mem_req = 1'b0;
            if (r_if_done) r_if_req = 1'b0;
            if (r_mem_done) r_mem_req = 1'b0;
        end
        check("drain_reqs_clear", {28'd0, if_req, mem_req, r_if_req, r_mem_req}, 32'd0);
        if_req = 1'b0; mem_req = 1'b0; r_if_req = 1'b0; r_mem_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_if_done"}, 32'(if_done), 32'd0);
        check({tag, "_if_data"}, if_data, 32'd0);
        check({tag, "_mem_done"}, 32'(mem_done), 32'd0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'd0);
        check({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
        check({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
    endtask

    initial begin
        int w0;
        fork
            run_monitor();
        join_none

        rst_n = 1'b0; rdy = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_size = 0; mem_wdata = 0;
        r_if_req = 0; r_if_addr = 0; r_if_flush = 0;
        r_mem_req = 0; r_mem_we = 0; r_mem_addr = 0; r_mem_size = 0; r_mem_wdata = 0;
        #2;
        check_outputs_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Reset in cycle 2 of a word store: outputs clear at once, no done.
        w0 = n_writes;
        mem_req = 1; mem_we = 1; mem_addr = 32'h300; mem_size = 2; mem_wdata = 32'h11223344;
        step();
        check("rst_wr_c1", 32'(ram_wr), 32'd1);
        check("rst_dout_c1", 32'(ram_dout), 32'h44);
        step();
        #1 rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1 check_outputs_zero("midrst");
        step();
        rst_n = 1'b1;
        idle(4);
        check("rst_write_count", n_writes - w0, 32'd1);

        // IF word fetch at 0x100.
        if_addr = 32'h100; if_req = 1;
        sb_q.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h93050013, cyc: cyc + 6});
        for (int k = 0; k < 4; k++) begin
            step();
            check("fetch_addr", ram_addr, 32'h100 + k);
            check("fetch_wr", 32'(ram_wr), 32'd0);
        end
        drain(20);
        idle(1);

        // MEM half store at 0x1004: only DD, CC go out.
        w0 = n_writes;
        mem_req = 1; mem_we = 1; mem_addr = 32'h1004; mem_size = 1; mem_wdata = 32'hAABBCCDD;
        sb_q.push_back('{is_mem: 1'b1, chk_data: 1'b0, data: 32'd0, cyc: cyc + 3});
        step();
        check("hs_addr0", ram_addr, 32'h1004);
        check("hs_wr0", 32'(ram_wr), 32'd1);
        check("hs_dout0", 32'(ram_dout), 32'hDD);
        step();
        check("hs_addr1", ram_addr, 32'h1005);
        check("hs_wr1", 32'(ram_wr), 32'd1);
        check("hs_dout1", 32'(ram_dout), 32'hCC);
        drain(20);
        mem_we = 0;
        idle(1);
        check("hs_write_count", n_writes - w0, 32'd2);
        check("hs_wr_idle", 32'(ram_wr), 32'd0);

        // Conflict, fixed priority: MEM byte load first, then the fetch.
        if_req = 1; if_addr = 32'h200;
        mem_req = 1; mem_we = 0; mem_addr = 32'h401; mem_size = 0;
        sb_q.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h00000056, cyc: cyc + 3});
        sb_q.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h100002B7, cyc: cyc + 10});
        drain(40);
        idle(1);

        // Flush in cycle 3 of a fetch, new fetch at 0x200 right behind it.
        if_req = 1; if_addr = 32'h100;
        idle(3);
        check("fl_addr_c3", ram_addr, 32'h102);
        if_flush = 1; if_addr = 32'h200;
        sb_q.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h100002B7, cyc: cyc + 7});
        step();
        check("fl_addr_hold", ram_addr, 32'h102);
        if_flush = 0;
        step();
        check("fl_new_addr", ram_addr, 32'h200);
        drain(20);
        idle(1);

        // Pause in cycles 2-4 of a MEM word load.
        mem_req = 1; mem_we = 0; mem_addr = 32'h400; mem_size = 2;
        sb_q.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h12345678, cyc: cyc + 9});
        step();
        check("pz_addr_c1", ram_addr, 32'h400);
        step();
        check("pz_addr_c2", ram_addr, 32'h401);
        rdy = 0;
        for (int k = 3; k <= 5; k++) begin
            step();
            check("pz_addr_hold", ram_addr, 32'h401);
            check("pz_wr", 32'(ram_wr), 32'd0);
        end
        rdy = 1;
        step();
        check("pz_addr_c6", ram_addr, 32'h402);
        drain(30);
        idle(1);

        // Byte store paused for one cycle: strobe forced low, done one late.
        w0 = n_writes;
        mem_req = 1; mem_we = 1; mem_addr = 32'h1008; mem_size = 0; mem_wdata = 32'h000000EE;
        sb_q.push_back('{is_mem: 1'b1, chk_data: 1'b0, data: 32'd0, cyc: cyc + 3});
        step();
        check("bp_wr_c1", 32'(ram_wr), 32'd1);
        rdy = 0;
        #1 check("bp_wr_paused", 32'(ram_wr), 32'd0);
        step();
        check("bp_addr_c2", ram_addr, 32'h1008);
        rdy = 1;
        #1 check("bp_wr_resume", 32'(ram_wr), 32'd1);
        drain(20);
        mem_we = 0;
        idle(1);
        check("bp_write_count", n_writes - w0, 32'd1);

        // Half load crossing the top of the address space.
        mem_req = 1; mem_we = 0; mem_addr = 32'hFFFFFFFF; mem_size = 1;
        sb_q.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h00005AA5, cyc: cyc + 4});
        step();
        check("wrap_addr0", ram_addr, 32'hFFFFFFFF);
        step();
        check("wrap_addr1", ram_addr, 32'h0);
        drain(20);
        idle(1);

        // Round-robin: IF wins the first conflict after reset, MEM the next.
        r_if_req = 1; r_if_addr = 32'h100;
        r_mem_req = 1; r_mem_we = 0; r_mem_addr = 32'h400; r_mem_size = 0;
        rr_q.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h93050013, cyc: cyc + 6});
        rr_q.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h00000078, cyc: cyc + 10});
        drain(40);
        idle(1);
        r_if_req = 1; r_mem_req = 1;
        rr_q.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h00000078, cyc: cyc + 3});
        rr_q.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h93050013, cyc: cyc + 10});
        drain(40);
        idle(3);

        check("sb_left", sb_q.size(), 32'd0);
        check("rr_left", rr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
